cr_huf_comp_stcl_parser: RTL and testbench

Reads packed short-tree code-length (STCL) words back out of the ST LUT and reconstructs the per-symbol code-length vector. It is the inverse of the STCL builder.
- Deflate mode: 3-bit fields in HCLEN permuted order.
- Non-deflate mode: delta-coded lengths.
- Used by the header checker and debug readback path to validate the LUT contents before the sequence assembler consumes them.

---
 rtl/cr_huf_comp_stcl_parser_if.sv | 34 +++
 rtl/cr_huf_comp_stcl_parser.sv | 173 +++++++++++++++++
 tb/tb_cr_huf_comp_stcl_parser.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cr_huf_comp_stcl_parser_if.sv
// Bundle of the STCL parser's control, ST LUT read port and result signals.
// Latency: none, wiring only; the LUT returns read data one cycle after st_lut_rd.
// Backpressure: none; the parser paces its own LUT reads and the consumer takes the sym_dpth_vld pulse.
interface cr_huf_comp_stcl_parser_if #(
  parameter int MAX_NUM_SYM_USED = 33,
  parameter int CODELENGTH_WIDTH = 4,
  parameter int HDR_WIDTH        = 64,
  parameter int ADDR_WIDTH       = 4,
  parameter int SIZE_WIDTH       = 9
);
  logic                                     start;
  logic                                     deflate_mode;
  logic [SIZE_WIDTH-1:0]                    stcl_size;
  logic [4:0]                               hclen;
  logic                                     st_lut_rd;
  logic [ADDR_WIDTH-1:0]                    st_lut_rd_addr;
  logic [HDR_WIDTH-1:0]                     st_lut_rd_data;
  logic [MAX_NUM_SYM_USED*CODELENGTH_WIDTH-1:0] sym_dpth;
  logic                                     sym_dpth_vld;
  logic                                     parse_err;
  logic                                     busy;

  // Requester and LUT side: starts jobs, returns LUT data, observes results.
  modport master (
    output start, deflate_mode, stcl_size, hclen, st_lut_rd_data,
    input  st_lut_rd, st_lut_rd_addr, sym_dpth, sym_dpth_vld, parse_err, busy
  );

  // Parser side.
  modport slave (
    input  start, deflate_mode, stcl_size, hclen, st_lut_rd_data,
    output st_lut_rd, st_lut_rd_addr, sym_dpth, sym_dpth_vld, parse_err, busy
  );
endinterface

// File: rtl/cr_huf_comp_stcl_parser.sv
// Rebuilds per-symbol short-tree code lengths from packed STCL words read back from the ST LUT.
// Latency: one LUT read plus one return cycle before the first decode, then one entry per cycle; DONE adds one cycle.
// Backpressure: none; reads are throttled internally so that the 2-word bit buffer never overflows.
module cr_huf_comp_stcl_parser #(
  parameter int MAX_NUM_SYM_USED = 33,
  parameter int CODELENGTH_WIDTH = 4,
  parameter int HDR_WIDTH        = 64,
  parameter int ADDR_WIDTH       = 4,
  parameter int SIZE_WIDTH       = 9
) (
  input logic                     clk,
  input logic                     rst,
  cr_huf_comp_stcl_parser_if.slave bus
);
  localparam int CW          = CODELENGTH_WIDTH;
  localparam int SYM_W       = MAX_NUM_SYM_USED * CW;
  localparam int BUF_W       = 2 * HDR_WIDTH;
  localparam int VB_W        = $clog2(BUF_W + 1);
  localparam int ENT_W       = $clog2(MAX_NUM_SYM_USED + 1);
  localparam int USED_W      = SIZE_WIDTH + 1;
  localparam int NUM_DEFLATE = 19;
  // HCLEN permutation, entry 0 in the low 5 bits.
  localparam logic [NUM_DEFLATE*5-1:0] DEFLATE_SEQ = {
    5'd15, 5'd1, 5'd14, 5'd2, 5'd13, 5'd3, 5'd12, 5'd4, 5'd11, 5'd5,
    5'd10, 5'd6, 5'd9, 5'd7, 5'd8, 5'd0, 5'd18, 5'd17, 5'd16
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic                  mode_q, rd_pend_q, perr_q;
  logic [SIZE_WIDTH-1:0] size_q, words_q, rd_cnt_q, rcv_cnt_q, words_start;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [VB_W-1:0]       vbits_q, vbits_d, vb_sub;
  logic [ENT_W-1:0]      ent_q, n_ent_q, n_ent_start, dec_idx, seq_sel;
  logic [CW-1:0]         prev_q, dec_len;
  logic [2:0]            dec_x, dec_cons, cons_eff;
  logic [USED_W-1:0]     used_q, used_d;
  logic [SYM_W-1:0]      sym_q;
  logic                  rd_fire, dec_fire, dec_last, vld;

  // Job sizing from the start-time inputs: words to fetch and entries to decode.
  always_comb begin
    words_start = SIZE_WIDTH'((int'(bus.stcl_size) + HDR_WIDTH - 1) / HDR_WIDTH);
    n_ent_start = ENT_W'(MAX_NUM_SYM_USED);
    if (bus.deflate_mode) begin
      // HCLEN beyond 15 cannot address the 19-entry permutation, so cap there.
      n_ent_start = (bus.hclen > 5'd15) ? ENT_W'(NUM_DEFLATE) : ENT_W'(int'(bus.hclen) + 4);
    end
  end

  // Decode the entry at the head of the bit buffer.
  always_comb begin
    dec_cons = 3'd1;
    dec_len  = prev_q;
    dec_idx  = ent_q;
    dec_x    = buf_q[3:1];
    seq_sel  = (ent_q < ENT_W'(NUM_DEFLATE)) ? ent_q : '0;
    if (mode_q) begin
      dec_cons = 3'd3;
      dec_len  = CW'(buf_q[2:0]);
      dec_idx  = ENT_W'(DEFLATE_SEQ[int'(seq_sel)*5 +: 5]);
    end else if (buf_q[0]) begin
      dec_cons = 3'd4;
      dec_len  = (CW'(dec_x) >= prev_q) ? CW'(dec_x) + CW'(1) : CW'(dec_x);
    end
  end

  assign dec_fire = (state_q == RUN) && ((vbits_q >= VB_W'(4)) || (rcv_cnt_q == words_q));
  assign dec_last = dec_fire && (ent_q == n_ent_q - ENT_W'(1));

  // Bit buffer: shift out consumed bits, then append any returning word at the remaining count.
  always_comb begin
    cons_eff = dec_fire ? dec_cons : 3'd0;
    // In the tail the decoder may consume past the valid count; those bits are zero.
    vb_sub   = (vbits_q > VB_W'(cons_eff)) ? vbits_q - VB_W'(cons_eff) : '0;
    buf_d    = buf_q >> cons_eff;
    vbits_d  = vb_sub;
    if (rd_pend_q) begin
      buf_d   = buf_d | ({{HDR_WIDTH{1'b0}}, bus.st_lut_rd_data} << vb_sub);
      vbits_d = vb_sub + VB_W'(HDR_WIDTH);
    end
    used_d = used_q + USED_W'(dec_cons);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, read strobe and completion pulse.
  always_comb begin
    state_d = state_q;
    rd_fire = 1'b0;
    vld     = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        rd_fire = (vbits_q <= VB_W'(HDR_WIDTH)) && (rd_cnt_q != words_q) && !rd_pend_q;
        if (dec_last) state_d = DONE;
      end
      DONE: begin
        vld     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job capture, fetch bookkeeping, buffer and decoded results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      size_q    <= '0;
      words_q   <= '0;
      n_ent_q   <= '0;
      rd_cnt_q  <= '0;
      rcv_cnt_q <= '0;
      rd_addr_q <= '0;
      rd_pend_q <= 1'b0;
      buf_q     <= '0;
      vbits_q   <= '0;
      ent_q     <= '0;
      prev_q    <= CW'(4);
      used_q    <= '0;
      sym_q     <= '0;
      perr_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        mode_q    <= bus.deflate_mode;
        size_q    <= bus.stcl_size;
        words_q   <= words_start;
        n_ent_q   <= n_ent_start;
        rd_cnt_q  <= '0;
        rcv_cnt_q <= '0;
        rd_addr_q <= '0;
        rd_pend_q <= 1'b0;
        buf_q     <= '0;
        vbits_q   <= '0;
        ent_q     <= '0;
        prev_q    <= CW'(4);
        used_q    <= '0;
        sym_q     <= '0;
        perr_q    <= 1'b0;
      end
    end else begin
      if (rd_fire) begin
        rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
        rd_cnt_q  <= rd_cnt_q + SIZE_WIDTH'(1);
      end
      rd_pend_q <= rd_fire;
      if (rd_pend_q) rcv_cnt_q <= rcv_cnt_q + SIZE_WIDTH'(1);
      buf_q   <= buf_d;
      vbits_q <= vbits_d;
      if (dec_fire) begin
        sym_q[int'(dec_idx)*CW +: CW] <= dec_len;
        prev_q <= dec_len;
        ent_q  <= ent_q + ENT_W'(1);
        used_q <= used_d;
        if (dec_last && (used_d != USED_W'(size_q))) perr_q <= 1'b1;
      end
    end
  end

  assign bus.st_lut_rd      = rd_fire;
  assign bus.st_lut_rd_addr = rd_addr_q;
  assign bus.sym_dpth       = sym_q;
  assign bus.sym_dpth_vld   = vld;
  assign bus.parse_err      = perr_q;
  assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_cr_huf_comp_stcl_parser.sv
// Bench for the STCL parser: directed and random jobs against a bit-stream reference model.
// Latency: results are matched whenever sym_dpth_vld appears, independent of cycle counts.
// Backpressure: none; the LUT model answers every read one cycle later.
`timescale 1ns/1ps
module tb_cr_huf_comp_stcl_parser;
  localparam int HDR  = 32;
  localparam int NSYM = 33;
  localparam int SYMW = NSYM * 4;

  typedef struct {
    logic [SYMW-1:0] sd;
    bit              perr;
    int              words;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   vld_cnt = 0;
  int   rd_seen = 0;
  exp_t sb[$];
  logic [HDR-1:0] lut [16];
  int   dseq [19] = '{16, 17, 18, 0, 8, 7, 9, 6, 10, 5, 11, 4, 12, 3, 13, 2, 14, 1, 15};

  cr_huf_comp_stcl_parser_if #(.HDR_WIDTH(HDR)) bus ();

  cr_huf_comp_stcl_parser #(
    .MAX_NUM_SYM_USED(NSYM), .CODELENGTH_WIDTH(4), .HDR_WIDTH(HDR), .ADDR_WIDTH(4), .SIZE_WIDTH(9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // LUT: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (bus.st_lut_rd) bus.st_lut_rd_data <= lut[bus.st_lut_rd_addr];
    else               bus.st_lut_rd_data <= $urandom;
  end

  task automatic check(input string name, input logic [SYMW-1:0] act, input logic [SYMW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit bitat(input int k, input int words);
    if (k >= words * HDR) return 1'b0;
    return lut[k / HDR][k % HDR];
  endfunction

  // Reference: walk the LSB-first stream entry by entry.
  function automatic void model(input bit dfl, input int size, input int hcl,
                                output logic [SYMW-1:0] sd, output bit perr, output int used);
    int words = (size + HDR - 1) / HDR;
    int pos = 0;
    int prev = 4;
    int len, x;
    sd = '0;
    if (dfl) begin
      for (int i = 0; i < hcl + 4; i++) begin
        len = bitat(pos, words) + 2 * bitat(pos + 1, words) + 4 * bitat(pos + 2, words);
        pos += 3;
        sd[dseq[i] * 4 +: 4] = 4'(len);
      end
    end else begin
      for (int i = 0; i < NSYM; i++) begin
        if (!bitat(pos, words)) begin
          len = prev;
          pos += 1;
        end else begin
          x = bitat(pos + 1, words) + 2 * bitat(pos + 2, words) + 4 * bitat(pos + 3, words);
          len = (x >= prev) ? x + 1 : x;
          pos += 4;
        end
        sd[i * 4 +: 4] = 4'(len);
        prev = len;
      end
    end
    used = pos;
    perr = (pos != size);
  endfunction

  // Monitor: read address sequence and result scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      rd_seen = 0;
    end else begin
      if (bus.start && !bus.busy) rd_seen = 0;
      if (bus.st_lut_rd) begin
        check("rd_addr", SYMW'(bus.st_lut_rd_addr), SYMW'(rd_seen % 16));
        rd_seen++;
      end
      if (bus.sym_dpth_vld) begin
        vld_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_vld", SYMW'(1), SYMW'(0));
        end else begin
          e = sb.pop_front();
          check("sym_dpth", bus.sym_dpth, e.sd);
          check("parse_err", SYMW'(bus.parse_err), SYMW'(e.perr));
          if (e.perr) check("rd_count_bound", SYMW'(rd_seen > e.words), SYMW'(0));
          else        check("rd_count", SYMW'(rd_seen), SYMW'(e.words));
        end
      end
    end
  end

  task automatic run_job(input bit dfl, input int size, input int hcl, input bit poke);
    exp_t e;
    int   used;
    int   base;
    model(dfl, size, hcl, e.sd, e.perr, used);
    e.words = (size + HDR - 1) / HDR;
    sb.push_back(e);
    base = vld_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.deflate_mode = dfl;
    bus.stcl_size = 9'(size);
    bus.hclen = 5'(hcl);
    @(negedge clk);
    bus.start = 1'b0;
    bus.deflate_mode = ~dfl;
    bus.stcl_size = 9'($urandom);
    bus.hclen = 5'($urandom);
    if (poke) begin
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int c = 0; c < 400 && vld_cnt == base; c++) @(negedge clk);
    if (vld_cnt == base) check("vld_timeout", SYMW'(0), SYMW'(1));
    @(negedge clk);
    check("busy_after_vld", SYMW'(bus.busy), SYMW'(0));
  endtask

  initial begin
    int dfl, hcl, size, used;
    bit perr;
    logic [SYMW-1:0] sd;
    bus.start = 1'b0;
    bus.deflate_mode = 1'b0;
    bus.stcl_size = '0;
    bus.hclen = '0;
    foreach (lut[i]) lut[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", SYMW'(bus.busy), SYMW'(0));
    check("rst_sym", bus.sym_dpth, SYMW'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", SYMW'(bus.busy), SYMW'(0));
    check("idle_rd", SYMW'(bus.st_lut_rd), SYMW'(0));
    check("idle_vld", SYMW'(bus.sym_dpth_vld), SYMW'(0));
    check("idle_perr", SYMW'(bus.parse_err), SYMW'(0));

    // All lengths 4, with a start pulse mid-run that must be ignored.
    run_job(1'b0, 33, 0, 1'b1);
    // First length 5 then a run of repeats; then first length 2.
    lut[0] = 32'h0000_0009;
    run_job(1'b0, 36, 0, 1'b0);
    lut[0] = 32'h0000_0005;
    run_job(1'b0, 36, 0, 1'b0);
    // Deflate, four entries.
    lut[0] = {20'h0, 3'd5, 3'd2, 3'd0, 3'd3};
    run_job(1'b1, 12, 0, 1'b0);
    // Deflate, 19 entries across two words with entry 10 straddling.
    foreach (lut[i]) lut[i] = $urandom;
    run_job(1'b1, 57, 15, 1'b0);
    // Size larger than the decoded stream; size zero.
    lut[0] = 32'h0000_0009;
    lut[1] = 32'h0;
    run_job(1'b0, 40, 0, 1'b0);
    run_job(1'b0, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      foreach (lut[i]) lut[i] = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom & $urandom & $urandom);
      dfl = $urandom_range(0, 1);
      hcl = $urandom_range(0, 15);
      if ($urandom_range(0, 2) != 0) begin
        model(dfl[0], 512, hcl, sd, perr, used);
        size = used;
      end else begin
        size = $urandom_range(0, 170);
      end
      run_job(dfl[0], size, hcl, 1'b0);
    end

    // Reset in the middle of a run: no result, outputs cleared.
    foreach (lut[i]) lut[i] = $urandom;
    @(negedge clk);
    bus.start = 1'b1;
    bus.deflate_mode = 1'b0;
    bus.stcl_size = 9'd100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", SYMW'(bus.busy), SYMW'(0));
    check("midrst_sym", bus.sym_dpth, SYMW'(0));
    check("midrst_vld", SYMW'(bus.sym_dpth_vld), SYMW'(0));
    check("midrst_perr", SYMW'(bus.parse_err), SYMW'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    model(1'b0, 512, 0, sd, perr, used);
    run_job(1'b0, used, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", SYMW'(sb.size()), SYMW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
